// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared MLP datapath types, constants and signed-magnitude helpers
`include "config.svh"

package mlp_pkg;

    localparam int FRAC_BITS = 17;
    localparam int ROWS      = 6;
    localparam int COLS      = 6;
    // Wide enough that COLS full-scale words can be summed without overflow.
    localparam int ACC_W     = `N + $clog2(COLS) + 1;

    typedef logic [`N-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_OUT
    } acc_state_t;

    // Signed-magnitude to two's complement at accumulator width; -0 maps to 0.
    function automatic logic signed [ACC_W-1:0] sm_to_tc(input word_t w);
        logic signed [ACC_W-1:0] mag;
        mag = $signed({{(ACC_W-`N+1){1'b0}}, w[`N-2:0]});
        return w[`N-1] ? -mag : mag;
    endfunction

endpackage

// File: rtl/config.svh
// rtl/config.svh - global datapath word width
`ifndef CONFIG_SVH
`define CONFIG_SVH
`ifndef N
`define N 32
`endif
`endif

// File: rtl/sm_saturate.sv
// rtl/sm_saturate.sv - two's complement to clamped signed-magnitude (optional RELU_EN)
`include "config.svh"

module sm_saturate
    import mlp_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_tc,
    output word_t                   o_data,
    output logic                    o_sat
);

    localparam logic [ACC_W-1:0] MAX_MAG = ACC_W'({(`N-1){1'b1}});

    logic             w_neg;
    logic [ACC_W-1:0] w_abs;
    logic [`N-2:0]    w_mag;

    assign w_neg = i_tc[ACC_W-1];
    assign w_abs = w_neg ? $unsigned(-i_tc) : $unsigned(i_tc);

    // Clamp the magnitude and build the output word; zero is always +0.
    always_comb begin
        o_sat = 1'b0;
        w_mag = w_abs[`N-2:0];
        if (w_abs > MAX_MAG) begin
            o_sat = 1'b1;
            w_mag = '1;
        end
`ifdef RELU_EN
        // Negative sums are rectified; o_sat still reflects the pre-ReLU clamp.
        if (w_neg || (w_abs == '0))
            o_data = '0;
        else
            o_data = {1'b0, w_mag};
`else
        if (w_abs == '0)
            o_data = '0;
        else
            o_data = {w_neg, w_mag};
`endif
    end

endmodule

// File: rtl/row_accumulator.sv
// rtl/row_accumulator.sv - serial per-row sum of a captured RxC matrix (macro RELU_EN)
`include "config.svh"

module row_accumulator
    import mlp_pkg::*;
#(
    parameter int R = ROWS,
    parameter int C = COLS
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [0:R-1][0:C-1][`N-1:0]   in_mat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [`N-1:0]                 out_data,
    output logic [$clog2(R)-1:0]          out_row,
    output logic                          out_last,
    output logic                          out_sat
);

    localparam int RW = $clog2(R);
    localparam int CW = $clog2(C);
    localparam logic [RW-1:0] ROW_LAST = RW'(R-1);
    localparam logic [CW-1:0] COL_LAST = CW'(C-1);

    acc_state_t                 r_state;
    acc_state_t                 w_state_next;
    logic [RW-1:0]              r_row;
    logic [CW-1:0]              r_col;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic [0:R-1][0:C-1][`N-1:0] r_mat;
    word_t                      r_out_data;
    logic [RW-1:0]              r_out_row;
    logic                       r_out_last;
    logic                       r_out_sat;
    word_t                      w_sat_data;
    logic                       w_sat_flag;
    logic                       w_cap;

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_OUT);
    assign w_cap      = in_valid & in_ready;
    assign w_acc_next = r_acc + sm_to_tc(r_mat[r_row][r_col]);

    assign out_data = r_out_data;
    assign out_row  = r_out_row;
    assign out_last = r_out_last;
    assign out_sat  = r_out_sat;

    // The final add of a row is converted directly so the sum lands in OUT without an extra cycle.
    sm_saturate u_sat (
        .i_tc   (w_acc_next),
        .o_data (w_sat_data),
        .o_sat  (w_sat_flag)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_cap)              w_state_next = ST_ACC;
            ST_ACC:  if (r_col == COL_LAST)  w_state_next = ST_OUT;
            ST_OUT:  if (out_ready)          w_state_next = (r_row == ROW_LAST) ? ST_IDLE : ST_ACC;
            default:                         w_state_next = ST_IDLE;
        endcase
    end

    // Matrix snapshot, taken only on the capture handshake.
    always_ff @(posedge clk) begin
        if (w_cap)
            r_mat <= in_mat;
    end

    // Row/column counters, accumulator and registered row result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_out_row  <= '0;
            r_out_last <= 1'b0;
            r_out_sat  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cap) begin
                        r_row <= '0;
                        r_col <= '0;
                        r_acc <= '0;
                    end
                end
                ST_ACC: begin
                    r_acc <= w_acc_next;
                    r_col <= r_col + 1'b1;
                    if (r_col == COL_LAST) begin
                        r_out_data <= w_sat_data;
                        r_out_sat  <= w_sat_flag;
                        r_out_row  <= r_row;
                        r_out_last <= (r_row == ROW_LAST);
                    end
                end
                ST_OUT: begin
                    if (out_ready && (r_row != ROW_LAST)) begin
                        r_row <= r_row + 1'b1;
                        r_col <= '0;
                        r_acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
